qtwos_decode: RTL and testbench

QTWOS_DECODE -- requirements
Module: qtwos_decode

---
 rtl/qtwos_decode.sv | 84 ++++++++
 tb/tb_qtwos_decode.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/qtwos_decode.sv
// Two-stage converter from 2Q-fraction two's complement to Q-fraction sign-magnitude,
// with round-half-away-from-zero, saturation and a saturating overflow counter.
module qtwos_decode #(
  parameter int Q = 8,
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*N-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_ovf,
  output logic [15:0]    sat_cnt,
  input  logic           clr_cnt
);

  localparam int W      = 2*N;
  localparam int RW     = W-Q+1;   // magnitude bits from the round bit upward
  localparam int STAGES = 1;

  // S1 keeps only the magnitude bits S2 consumes: integer part plus round bit.
  typedef struct packed {
    logic          sign;
    logic          minneg;
    logic [RW-1:0] mag_hi;
  } s1_t;

  logic [STAGES:0] vld_pipe;
  logic            advance;
  s1_t             s1_d, s1_q;
  logic [RW-1:0]   rounded;
  logic            ovf_d;
  logic [N-2:0]    mag_d;
  logic            sgn_d;

  assign advance   = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];

  // Upper bits of -x are ~x_hi plus a carry that only survives when the dropped low bits are zero.
  always_comb begin
    s1_d        = '0;
    s1_d.sign   = in_data[W-1];
    s1_d.minneg = (in_data == {1'b1, {(W-1){1'b0}}});
    if (s1_d.sign)
      s1_d.mag_hi = ~in_data[W-1:Q-1] + RW'(in_data[Q-2:0] == '0);
    else
      s1_d.mag_hi = in_data[W-1:Q-1];
  end

  always_comb begin
    rounded = {1'b0, s1_q.mag_hi[RW-1:1]} + RW'(s1_q.mag_hi[0]);
    ovf_d   = s1_q.minneg || (|rounded[RW-1:N-1]);
    mag_d   = ovf_d ? {(N-1){1'b1}} : rounded[N-2:0];
    sgn_d   = s1_q.sign && (mag_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      s1_q     <= s1_d;
      out_data <= {sgn_d, mag_d};
      out_ovf  <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_cnt <= '0;
    else if (clr_cnt)
      sat_cnt <= '0;
    else if (out_valid && out_ready && out_ovf && (sat_cnt != 16'hFFFF))
      sat_cnt <= sat_cnt + 16'd1;
  end

endmodule

// File: tb/tb_qtwos_decode.sv
// Bench for qtwos_decode: directed vector table, stall/reset sequences and a random
// sweep, all scored against an arithmetic reference model.
module tb_qtwos_decode;
  localparam int Q = 8;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [2*N-1:0] in_data = '0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic           clr_cnt = 1'b0;
  logic           in_ready, out_valid, out_ovf;
  logic [N-1:0]   out_data;
  logic [15:0]    sat_cnt;

  qtwos_decode #(.Q(Q), .N(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_ovf(out_ovf),
    .sat_cnt(sat_cnt), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_got = 0;
  int exp_sat = 0;
  logic [N:0] exp_q[$];

  typedef struct {
    logic [2*N-1:0] din;
    logic [N-1:0]   dout;
    logic           ovf;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic on the real value, {ovf, sign, magnitude}.
  function automatic logic [N:0] model(input logic [2*N-1:0] d);
    longint v, a, r;
    logic [N-2:0] m;
    logic o, s;
    v = longint'($signed(d));
    a = (v < 0) ? -v : v;
    r = (a + (longint'(1) << (Q-1))) >>> Q;
    o = (r >= (longint'(1) << (N-1)));
    m = o ? {(N-1){1'b1}} : r[N-2:0];
    s = (v < 0) && (m != '0);
    return {o, s, m};
  endfunction

  function automatic logic [2*N-1:0] rnd_data();
    logic [31:0] r, v;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: v = r;
      1: v = {{16{r[15]}}, r[15:0]};
      2: begin
        v = 32'h007FFF00 + $urandom_range(0, 255);
        if (r[0]) v = -v;
      end
      3: v = {{9{r[22]}}, r[22:8], 8'h80};
      default: v = 32'h80000000;
    endcase
    return v;
  endfunction

  // Scoreboard: outputs are checked in order against modelled accepted inputs.
  always @(negedge clk) begin
    logic [N:0] e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_got++;
        if (exp_q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("sb_data", 32'(out_data), 32'(e[N-1:0]));
          chk("sb_ovf", 32'(out_ovf), 32'(e[N]));
          if (clr_cnt) exp_sat = 0;
          else if (e[N] && exp_sat < 65535) exp_sat++;
        end
      end else if (clr_cnt) exp_sat = 0;
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
    end
  end

  task automatic run_vec(input int i);
    string nm;
    nm = $sformatf("vec%0d", i);
    @(posedge clk); #1;
    in_data = tbl[i].din; in_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_data"}, 32'(out_data), 32'(tbl[i].dout));
    chk({nm, "_ovf"}, 32'(out_ovf), 32'(tbl[i].ovf));
  endtask

  logic [N:0] ma;
  int n0;

  initial begin
    tbl[0] = '{32'h00018000, 16'h0180, 1'b0};
    tbl[1] = '{32'hFFFE8000, 16'h8180, 1'b0};
    tbl[2] = '{32'h00000080, 16'h0001, 1'b0};
    tbl[3] = '{32'hFFFFFF80, 16'h8001, 1'b0};
    tbl[4] = '{32'hFFFFFFC0, 16'h0000, 1'b0};
    tbl[5] = '{32'h0000007F, 16'h0000, 1'b0};
    tbl[6] = '{32'h00800000, 16'h7FFF, 1'b1};
    tbl[7] = '{32'h80000000, 16'hFFFF, 1'b1};
    tbl[8] = '{32'h007FFF7F, 16'h7FFF, 1'b0};

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i);
    @(negedge clk);
    chk("sat_cnt_after_tbl", 32'(sat_cnt), 32'd2);

    // Clear coinciding with an overflow handshake
    @(posedge clk); #1;
    in_data = 32'h00800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    clr_cnt = 1'b1;
    @(negedge clk);
    chk("clr_ovf_pending", 32'({out_valid, out_ovf}), 32'd3);
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_priority", 32'(sat_cnt), 32'd0);

    // Backpressure: 4 back-to-back items, 3-cycle stall mid-stream
    n0 = n_got;
    ma = model(32'h00018000);
    @(posedge clk); #1;
    in_data = 32'h00018000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 32'h80000000;
    @(posedge clk); #1;
    in_data = 32'hFFFE8000; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(ma[N-1:0]));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_data = 32'h00000080;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_delivered", 32'(n_got - n0), 32'd4);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("bp_sat_cnt", 32'(sat_cnt), 32'(exp_sat));

    // Reset with two items in flight
    @(posedge clk); #1;
    in_data = 32'h00800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 32'h00000080;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    exp_sat = 0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end

    // Random sweep with random handshakes and occasional clears
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      clr_cnt   = ($urandom_range(0, 199) == 0);
      in_data   = rnd_data();
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (5) @(negedge clk);
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);
    chk("rnd_sat_cnt", 32'(sat_cnt), 32'(exp_sat));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
